// File: rtl/oob_dev.sv
// oob_dev: SATA device-side out-of-band (OOB) handshake.
// It answers a host COMRESET with COMINIT, answers COMWAKE with COMWAKE,
// sends ALIGN primitives until the host sends ALIGN back, and then passes
// data through in READY.
module oob_dev #(
    parameter int          DATA_BYTE_WIDTH = 4,
    parameter int          OOB_BURST_CLKS  = 160,
    parameter logic [15:0] COMWAKE_TIMEOUT = 16'd8192,
    parameter logic [15:0] ALIGN_TIMEOUT   = 16'd4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         gtx_ready,
    input  logic                         rxcominitdet_in,
    input  logic                         rxcomwakedet_in,
    input  logic                         rxelecidle_in,
    input  logic                         rxbyteisaligned,
    input  logic [DATA_BYTE_WIDTH*8-1:0] rxdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   rxcharisk_in,
    input  logic [DATA_BYTE_WIDTH*8-1:0] txdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   txcharisk_in,
    output logic                         txcominit,
    output logic                         txcomwake,
    output logic                         txelecidle,
    output logic [DATA_BYTE_WIDTH*8-1:0] txdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]   txcharisk_out,
    output logic [DATA_BYTE_WIDTH*8-1:0] rxdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]   rxcharisk_out,
    output logic                         phy_ready
);

    localparam int DW = DATA_BYTE_WIDTH * 8;
    localparam int KW = DATA_BYTE_WIDTH;

    localparam logic [DW-1:0] ALIGN_DATA  = 32'h7B4A4ABC;
    localparam logic [KW-1:0] ALIGN_K     = 4'b0001;
    localparam logic [15:0]   BURST_LAST  = 16'(OOB_BURST_CLKS - 1);
    localparam logic [15:0]   CWAKE_LAST  = COMWAKE_TIMEOUT - 16'd1;
    localparam logic [15:0]   ALIGN_LAST  = ALIGN_TIMEOUT - 16'd1;

    typedef enum logic [2:0] {
        IDLE,
        SEND_COMINIT,
        WAIT_COMINIT,
        WAIT_COMWAKE,
        SEND_COMWAKE,
        WAIT_COMWAKE_END,
        SEND_ALIGN,
        READY
    } state_t;

    state_t      state;
    state_t      next;
    logic [15:0] cnt;
    logic        align_match;

    assign align_match = rxbyteisaligned && (rxcharisk_in == ALIGN_K)
                         && (rxdata_in == ALIGN_DATA);

    // Next-state decode; global aborts override the state-local transitions.
    always_comb begin
        next = state;
        unique case (state)
            IDLE:             if (gtx_ready && rxcominitdet_in) next = SEND_COMINIT;
            SEND_COMINIT:     next = WAIT_COMINIT;
            WAIT_COMINIT:     if (cnt == BURST_LAST) next = WAIT_COMWAKE;
            WAIT_COMWAKE: begin
                if (rxcomwakedet_in)          next = SEND_COMWAKE;
                else if (cnt == CWAKE_LAST)   next = SEND_COMINIT;
            end
            SEND_COMWAKE:     next = WAIT_COMWAKE_END;
            WAIT_COMWAKE_END: if (cnt >= BURST_LAST && !rxelecidle_in) next = SEND_ALIGN;
            SEND_ALIGN: begin
                if (align_match)              next = READY;
                else if (cnt == ALIGN_LAST)   next = IDLE;
            end
            READY:            if (rxelecidle_in && cnt == BURST_LAST) next = IDLE;
            default:          next = IDLE;
        endcase
        if (rxcominitdet_in && state != IDLE && state != SEND_COMINIT)
            next = SEND_COMINIT;
        if (!gtx_ready)
            next = IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // Shared cycle counter: clears on state entry and saturates. In READY it
    // counts consecutive rx electrical-idle cycles, so it also clears on any
    // non-idle cycle there.
    always_ff @(posedge clk) begin
        if (rst)                                   cnt <= '0;
        else if (next != state)                    cnt <= '0;
        else if (state == READY && !rxelecidle_in) cnt <= '0;
        else if (cnt != '1)                        cnt <= cnt + 16'd1;
    end

    // Tx-side outputs are registered from the next state so they line up
    // with the state register rather than lagging it by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            txcominit     <= 1'b0;
            txcomwake     <= 1'b0;
            txelecidle    <= 1'b1;
            phy_ready     <= 1'b0;
            txdata_out    <= '0;
            txcharisk_out <= '0;
        end else begin
            txcominit     <= (next == SEND_COMINIT);
            txcomwake     <= (next == SEND_COMWAKE);
            txelecidle    <= !(next == SEND_ALIGN || next == READY);
            phy_ready     <= (next == READY);
            txdata_out    <= '0;
            txcharisk_out <= '0;
            if (next == SEND_ALIGN) begin
                txdata_out    <= ALIGN_DATA;
                txcharisk_out <= ALIGN_K;
            end else if (next == READY) begin
                txdata_out    <= txdata_in;
                txcharisk_out <= txcharisk_in;
            end
        end
    end

    // Rx word pass-through with one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxdata_out    <= '0;
            rxcharisk_out <= '0;
        end else begin
            rxdata_out    <= rxdata_in;
            rxcharisk_out <= rxcharisk_in;
        end
    end

endmodule
